// File: rtl/cordic_rotation_scheduler.sv
// Round-robin scheduler sharing one CORDIC rotator among NUM_REQ requesters.
// Optional GAIN_COMP_EN adds a COMP state that scales results by 1/1.6468.
module cordic_rotation_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 16,
    parameter int CORDIC_LAT = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_x,
    input  logic [NUM_REQ*DATA_W-1:0]  req_y,
    input  logic [NUM_REQ*DATA_W-1:0]  req_phi,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_x,
    output logic [DATA_W-1:0]          resp_y,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       busy,
    output logic                       cordic_rst,
    output logic [DATA_W-1:0]          cordic_x,
    output logic [DATA_W-1:0]          cordic_y,
    output logic [DATA_W-1:0]          cordic_phi,
    input  logic [DATA_W-1:0]          cordic_x_out,
    input  logic [DATA_W-1:0]          cordic_y_out
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(CORDIC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_COMP,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   op_id;
    logic [DATA_W-1:0] op_x;
    logic [DATA_W-1:0] op_y;
    logic [DATA_W-1:0] op_phi;
    logic [CW-1:0]    cnt;
    logic             found;
    logic [IDW-1:0]   gnt;
    logic [IDW:0]     scan;
    logic             accept;
    logic             last_iter;

    // Search starts at rr_ptr and wraps, so the first hit is the fair winner
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NUM_REQ))
                scan = scan - (IDW+1)'(NUM_REQ);
            if (!found && req_valid[scan[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = scan[IDW-1:0];
            end
        end
    end

    assign accept    = (state == S_IDLE) && found;
    assign last_iter = (state == S_WAIT) && (cnt == CW'(CORDIC_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cordic_rst = 1'b1;
        busy       = 1'b1;
        resp_valid = 1'b0;
        req_ready  = '0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (found) begin
                    req_ready  = NUM_REQ'(1) << gnt;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT: begin
                cordic_rst = 1'b0;
                if (last_iter) begin
`ifdef GAIN_COMP_EN
                    state_next = S_COMP;
`else
                    state_next = S_RESP;
`endif
                end
            end
            S_COMP: state_next = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef GAIN_COMP_EN
    localparam logic signed [31:0] GAIN = 32'sh0000_4DBA;

    logic signed [31:0] prod_x;
    logic signed [31:0] prod_y;
    logic signed [31:0] sh_x;
    logic signed [31:0] sh_y;

    function automatic logic [DATA_W-1:0] sat(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return DATA_W'(16'h7FFF);
        else if (v < -32'sd32768)
            return DATA_W'(16'h8000);
        else
            return v[DATA_W-1:0];
    endfunction

    assign prod_x = 32'($signed(resp_x)) * GAIN;
    assign prod_y = 32'($signed(resp_y)) * GAIN;
    assign sh_x   = prod_x >>> 15;
    assign sh_y   = prod_y >>> 15;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            op_id  <= '0;
            op_x   <= '0;
            op_y   <= '0;
            op_phi <= '0;
            cnt    <= '0;
            resp_x <= '0;
            resp_y <= '0;
        end else begin
            if (accept) begin
                op_x   <= req_x[int'(gnt)*DATA_W +: DATA_W];
                op_y   <= req_y[int'(gnt)*DATA_W +: DATA_W];
                op_phi <= req_phi[int'(gnt)*DATA_W +: DATA_W];
                op_id  <= gnt;
                rr_ptr <= (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + IDW'(1);
            end
            cnt <= (state == S_WAIT) ? cnt + CW'(1) : '0;
            if (last_iter) begin
                resp_x <= cordic_x_out;
                resp_y <= cordic_y_out;
            end
`ifdef GAIN_COMP_EN
            if (state == S_COMP) begin
                resp_x <= sat(sh_x);
                resp_y <= sat(sh_y);
            end
`endif
        end
    end

    // Operands stay on the rotator inputs for the whole op; phi is re-read every iteration
    assign cordic_x   = op_x;
    assign cordic_y   = op_y;
    assign cordic_phi = op_phi;
    assign resp_id    = op_id;

endmodule
